lut_config_loader: RTL and testbench

Configuration sequencer for a bank of fractured LUTs. It accepts configuration words over a valid/ready stream and packs them into full `MEM_SIZE`-bit frames. It then writes each frame into one LUT using that LUT's block-style `config_en`/`config_in` port. It sits between the tile's configuration fabric and the `NUM_LUTS` LUTs of a CLB, and one `start` pulse programs every LUT in the bank in order.

---
 rtl/lut_cfg_pkg.sv | 24 ++
 rtl/lut_cfg_shifter.sv | 67 ++++++
 rtl/lut_config_loader.sv | 135 +++++++++++++
 tb/tb_lut_config_loader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_cfg_pkg.sv
// Shared types and sizing helpers for the LUT configuration loader.
// Holds the loader FSM state enum and counter-width helpers.
package lut_cfg_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_COMMIT,
        S_DONE
    } state_e;

    // Counter width for n distinct values, never below one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int words_per_frame(
        input int mem_size,
        input int word_w
    );
        return mem_size / word_w;
    endfunction

endpackage

// File: rtl/lut_cfg_shifter.sv
// Word-to-frame assembly register for the LUT configuration loader.
// Ports: clk_i, rst_ni (async, active-low); word_i/parity_i stream word;
//   we_i write strobe, idx_i word slot, clr_i clears the frame-bad flag;
//   frame_o assembled frame; bad_o frame-bad including the word now
//   being written. Parity checking exists only with LUT_CFG_PARITY_EN.
module lut_cfg_shifter
    import lut_cfg_pkg::*;
#(
    parameter int MEM_SIZE = 16,
    parameter int WORD_W   = 8,
    parameter int WPF      = 2,
    parameter int WCW      = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [WORD_W-1:0]   word_i,
    input  logic                parity_i,
    input  logic                we_i,
    input  logic [WCW-1:0]      idx_i,
    input  logic                clr_i,
    output logic [MEM_SIZE-1:0] frame_o,
    output logic                bad_o
);

    logic [MEM_SIZE-1:0] frame_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_q <= '0;
        end else if (we_i) begin
            for (int k = 0; k < WPF; k++) begin
                if (idx_i == WCW'(k)) begin
                    frame_q[k*WORD_W +: WORD_W] <= word_i;
                end
            end
        end
    end

    assign frame_o = frame_q;

`ifdef LUT_CFG_PARITY_EN
    logic bad_q;
    logic word_bad;

    // Even parity: {word, parity} must XOR to zero.
    assign word_bad = we_i & (^{word_i, parity_i});

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bad_q <= 1'b0;
        end else if (clr_i) begin
            bad_q <= 1'b0;
        end else if (word_bad) begin
            bad_q <= 1'b1;
        end
    end

    // Include the current word so the last word of a frame
    // already counts when the commit strobe is registered.
    assign bad_o = bad_q | word_bad;
`else
    logic unused_ok;
    assign unused_ok = ^{parity_i, clr_i};
    assign bad_o     = 1'b0;
`endif

endmodule

// File: rtl/lut_config_loader.sv
// Configuration sequencer: packs stream words into LUT frames and
// writes each frame into one LUT of the bank, LUT 0 first.
// Ports: config_clk, config_rst_n (async, active-low); start;
//   in_data/in_parity/in_valid/in_ready word stream; cfg_data frame,
//   cfg_en one-hot LUT strobe; busy, done pulse, err sticky flag.
// Optional parity checking is enabled with LUT_CFG_PARITY_EN.
module lut_config_loader
    import lut_cfg_pkg::*;
#(
    parameter int INPUTS   = 4,
    parameter int MEM_SIZE = 2**INPUTS,
    parameter int WORD_W   = 8,
    parameter int NUM_LUTS = 4
) (
    input  logic                config_clk,
    input  logic                config_rst_n,
    input  logic                start,
    input  logic [WORD_W-1:0]   in_data,
    input  logic                in_parity,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [MEM_SIZE-1:0] cfg_data,
    output logic [NUM_LUTS-1:0] cfg_en,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int WPF = words_per_frame(MEM_SIZE, WORD_W);
    localparam int WCW = cnt_w(WPF);
    localparam int LCW = cnt_w(NUM_LUTS);

    state_e              state_q;
    logic [WCW-1:0]      wcnt_q;
    logic [LCW-1:0]      lut_q;
    logic                in_ready_q;
    logic [NUM_LUTS-1:0] cfg_en_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    logic accept;
    logic last_word;
    logic last_lut;
    logic sh_clr;
    logic frame_bad;

    assign accept    = (state_q == S_SHIFT) & in_valid & in_ready_q;
    assign last_word = (wcnt_q == WCW'(WPF - 1));
    assign last_lut  = (lut_q == LCW'(NUM_LUTS - 1));
    assign sh_clr    = ((state_q == S_IDLE) & start)
                     | (state_q == S_COMMIT);

    lut_cfg_shifter #(
        .MEM_SIZE (MEM_SIZE),
        .WORD_W   (WORD_W),
        .WPF      (WPF),
        .WCW      (WCW)
    ) u_shifter (
        .clk_i    (config_clk),
        .rst_ni   (config_rst_n),
        .word_i   (in_data),
        .parity_i (in_parity),
        .we_i     (accept),
        .idx_i    (wcnt_q),
        .clr_i    (sh_clr),
        .frame_o  (cfg_data),
        .bad_o    (frame_bad)
    );

    always_ff @(posedge config_clk or negedge config_rst_n) begin
        if (!config_rst_n) begin
            state_q    <= S_IDLE;
            wcnt_q     <= '0;
            lut_q      <= '0;
            in_ready_q <= 1'b0;
            cfg_en_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cfg_en_q <= '0;
            done_q   <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_SHIFT;
                        wcnt_q     <= '0;
                        lut_q      <= '0;
                        err_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (accept) begin
                        if (last_word) begin
                            state_q    <= S_COMMIT;
                            in_ready_q <= 1'b0;
                            // A bad frame is never written.
                            if (!frame_bad) begin
                                cfg_en_q <= NUM_LUTS'(1) << lut_q;
                            end
                        end else begin
                            wcnt_q <= wcnt_q + WCW'(1);
                        end
                    end
                end
                S_COMMIT: begin
                    if (frame_bad || last_lut) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        err_q   <= frame_bad;
                    end else begin
                        state_q    <= S_SHIFT;
                        lut_q      <= lut_q + LCW'(1);
                        wcnt_q     <= '0;
                        in_ready_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign cfg_en   = cfg_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_lut_config_loader.sv
// Self-checking bench for lut_config_loader (INPUTS=4, WORD_W=8,
// NUM_LUTS=4); behavioural model of frame order, timing and parity.
module tb_lut_config_loader;

    localparam int MEM_SIZE = 16;
    localparam int NL       = 4;
    localparam int NW       = 8;
    localparam int MAXC     = 200;

    logic                config_clk = 1'b0;
    logic                config_rst_n;
    logic                start;
    logic [7:0]          in_data;
    logic                in_parity;
    logic                in_valid;
    logic                in_ready;
    logic [MEM_SIZE-1:0] cfg_data;
    logic [NL-1:0]       cfg_en;
    logic                busy;
    logic                done;
    logic                err;

    int errors = 0;
    int checks = 0;

    logic [7:0] words [NW];
    bit         vpat  [MAXC];

    always #5 config_clk = ~config_clk;

    lut_config_loader #(
        .INPUTS   (4),
        .WORD_W   (8),
        .NUM_LUTS (NL)
    ) dut (
        .config_clk   (config_clk),
        .config_rst_n (config_rst_n),
        .start        (start),
        .in_data      (in_data),
        .in_parity    (in_parity),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .cfg_data     (cfg_data),
        .cfg_en       (cfg_en),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_cfg_en"}, cfg_en, 0);
        check({tag, "_cfg_data"}, cfg_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic set_fixed_words();
        words = '{8'h34, 8'h12, 8'h78, 8'h56,
                  8'hBC, 8'h9A, 8'hF0, 8'hDE};
    endtask

    task automatic set_rand_words();
        for (int i = 0; i < NW; i++) words[i] = 8'($urandom);
    endtask

    task automatic all_valid();
        for (int i = 0; i < MAXC; i++) vpat[i] = 1'b1;
    endtask

    task automatic rand_valid();
        for (int i = 0; i < MAXC; i++)
            vpat[i] = (i >= 60) ? 1'b1 : ($urandom_range(0, 9) < 7);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge config_clk); #1;
            start     = 1'b0;
            in_valid  = 1'b1;
            in_data   = 8'($urandom);
            in_parity = 1'($urandom);
            @(negedge config_clk);
            check("idle_in_ready", in_ready, 0);
            check("idle_cfg_en", cfg_en, 0);
            check("idle_busy", busy, 0);
        end
    endtask

    // badk: index of the word sent with wrong parity (-1: none).
    // bstart: cycle of an extra start pulse while busy (-1: none).
    // rst_at: cycle at which reset is asserted (-1: none).
    task automatic run_load(
        input int badk_in,
        input int bstart,
        input int rst_at
    );
        int              badk, t, k, n, edone, np, ptr, seen;
        bit              bad;
        bit              eshift [MAXC];
        int              ecyc   [NL];
        logic [NL-1:0]   een    [NL];
        logic [15:0]     efr    [NL];
        logic [NL-1:0]   exp_en;

        badk = badk_in;
`ifndef LUT_CFG_PARITY_EN
        badk = -1;
`endif
        for (int i = 0; i < MAXC; i++) eshift[i] = 1'b0;
        t = 1; k = 0; n = 0; edone = 0;
        for (int l = 0; l < NL; l++) begin
            bad = 1'b0;
            for (int j = 0; j < 2; j++) begin
                while (!vpat[t]) begin
                    eshift[t] = 1'b1;
                    t++;
                end
                eshift[t] = 1'b1;
                if (k == badk) bad = 1'b1;
                k++;
                t++;
            end
            edone = t + 1;
            if (bad) break;
            ecyc[n] = t;
            een[n]  = NL'(1 << l);
            efr[n]  = {words[2*l+1], words[2*l]};
            n++;
            t++;
        end

        np = 0; ptr = 0; seen = 0;
        for (int c = 0; c <= edone; c++) begin
            @(posedge config_clk); #1;
            start    = (c == 0) || (c == bstart);
            in_valid = (c == 0) ? 1'b1 : vpat[c];
            in_data  = (ptr < NW) ? words[ptr] : 8'($urandom);
`ifdef LUT_CFG_PARITY_EN
            in_parity = (^in_data) ^ (ptr == badk);
`else
            in_parity = 1'($urandom);
`endif
            if (c == rst_at) begin
                #2 config_rst_n = 1'b0;
                #1 check_reset_vals("async_rst");
                start    = 1'b0;
                in_valid = 1'b1;
                @(posedge config_clk); #1;
                check_reset_vals("held_rst");
                config_rst_n = 1'b1;
                in_valid     = 1'b0;
                return;
            end
            @(negedge config_clk);
            exp_en = (np < n && c == ecyc[np]) ? een[np] : '0;
            if (cfg_en != 0) seen++;
            check("cfg_en", cfg_en, exp_en);
            if (exp_en != 0) begin
                check("cfg_data", cfg_data, efr[np]);
                np++;
            end
            check("in_ready", in_ready, eshift[c]);
            check("busy", busy, c >= 1);
            check("done", done, c == edone);
            if (c >= 1)
                check("err", err, (c == edone) && (badk >= 0));
            if (in_valid && in_ready) ptr++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check("pulse_count", seen, n);
        if (n > 0) check("cfg_data_hold", cfg_data, efr[n-1]);
    endtask

    initial begin
        config_rst_n = 1'b0;
        start        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_parity    = 1'b0;
        #3;
        check_reset_vals("por");
        @(negedge config_clk);
        config_rst_n = 1'b1;
        idle(2);

        set_fixed_words();
        all_valid();
        run_load(-1, -1, -1);
        idle(3);

        set_fixed_words();
        all_valid();
        for (int i = 2; i <= 6; i++) vpat[i] = 1'b0;
        run_load(-1, -1, -1);
        idle(2);

        set_rand_words();
        all_valid();
        run_load(-1, 4, -1);
        idle(2);

        set_rand_words();
        all_valid();
        run_load(-1, -1, 7);
        set_fixed_words();
        run_load(-1, -1, -1);
        idle(2);

        set_rand_words();
        all_valid();
        run_load(2, -1, -1);
        set_fixed_words();
        run_load(-1, -1, -1);
        idle(1);

        for (int r = 0; r < 6; r++) begin
            set_rand_words();
            rand_valid();
            run_load(-1, -1, -1);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule
